echo_requester: RTL and testbench

- Initiator end of the Echo request/indication protocol.
- Issues a programmed run of say requests (meth, v) and accepts each heard indication.
- Compares each indication against the expected echo and keeps pass/error counts.
- Used as on-chip traffic source and self-checker in front of Echo, and as a bench driver.

---
 rtl/echo_pkg.sv | 21 ++
 rtl/echo_requester.sv | 164 ++++++++++++++++
 tb/tb_echo_requester.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared types and widths for the Echo protocol initiator.
// Holds the requester FSM states and the saturating counter helper.
package echo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int METH_W = 32;
    localparam int V_W    = 32;
    localparam int CNT_W  = 16;

    // Event counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

endpackage

// File: rtl/echo_requester.sv
// Echo protocol initiator: issues a programmed run of say requests, one at a
// time, and scores every heard indication against the expected echo.
module echo_requester
    import echo_pkg::*;
#(
    parameter int          TIMEOUT = 1024,
    parameter logic [31:0] V_STEP  = 32'h1
) (
    input  logic              CLK,
    input  logic              nRST,

    input  logic              start__ENA,
    input  logic [CNT_W-1:0]  start_count,
    input  logic [V_W-1:0]    start_seed,
    output logic              start__RDY,

    output logic              request_say__ENA,
    output logic [METH_W-1:0] request_say_meth,
    output logic [V_W-1:0]    request_say_v,
    input  logic              request_say__RDY,

    input  logic              indication_heard__ENA,
    input  logic [METH_W-1:0] indication_heard_meth,
    input  logic [V_W-1:0]    indication_heard_v,
    output logic              indication_heard__RDY,

    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              timeout
);

    // A zero TIMEOUT still needs a legal one-bit counter even though it never counts.
    localparam int                 WAIT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam bit                 TO_EN      = (TIMEOUT != 0);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   index_q;
    logic [CNT_W-1:0]   count_q;
    logic [V_W-1:0]     seed_q;
    logic [CNT_W-1:0]   pass_q;
    logic [CNT_W-1:0]   err_q;
    logic               timeout_q;
    logic [WAIT_W-1:0]  wait_q;

    logic               start_fire;
    logic               say_fire;
    logic               heard_fire;
    logic [CNT_W-1:0]   index_inc;
    logic               more_left;
    logic [V_W-1:0]     expected_v;
    logic               heard_match;
    logic [WAIT_W-1:0]  wait_inc;
    logic               wait_expired;

    assign start_fire   = start__ENA && start__RDY;
    assign say_fire     = request_say__ENA;
    assign heard_fire   = indication_heard__ENA && indication_heard__RDY;

    // index < count always holds in WAIT, so index+1 cannot overflow 16 bits.
    assign index_inc    = index_q + 1'b1;
    assign more_left    = (index_inc < count_q);
    assign expected_v   = seed_q + V_W'(index_q) * V_STEP;
    assign heard_match  = (indication_heard_meth == METH_W'(index_q)) &&
                          (indication_heard_v == expected_v);
    assign wait_inc     = wait_q + 1'b1;
    assign wait_expired = TO_EN && (wait_inc == WAIT_LIMIT);

    assign pass_count   = pass_q;
    assign err_count    = err_q;
    assign timeout      = timeout_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_fire) begin
                    state_next = (start_count == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (say_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (heard_fire) begin
                    state_next = more_left ? SEND : DONE;
                end else if (wait_expired) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start__RDY            = (state == IDLE) || (state == DONE);
        indication_heard__RDY = (state != SEND);
        done                  = (state == DONE);
        request_say__ENA      = 1'b0;
        request_say_meth      = '0;
        request_say_v         = '0;
        if (state == SEND) begin
            request_say__ENA = request_say__RDY;
            request_say_meth = METH_W'(index_q);
            request_say_v    = expected_v;
        end
    end

    // Run bookkeeping: a fresh start wins over any indication arriving alongside it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            index_q   <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            pass_q    <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else if (start_fire) begin
            index_q   <= '0;
            count_q   <= start_count;
            seed_q    <= start_seed;
            pass_q    <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else if (heard_fire) begin
            if (state == WAIT) begin
                if (heard_match) begin
                    pass_q <= sat_inc(pass_q);
                end else begin
                    err_q  <= sat_inc(err_q);
                end
                index_q <= index_inc;
            end else begin
                err_q <= sat_inc(err_q);
            end
        end else if ((state == WAIT) && wait_expired) begin
            timeout_q <= 1'b1;
            err_q     <= sat_inc(err_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_q <= '0;
        end else if (say_fire) begin
            wait_q <= '0;
        end else if (TO_EN && (state == WAIT) && !heard_fire) begin
            wait_q <= wait_inc;
        end
    end

endmodule

// File: tb/tb_echo_requester.sv
// Randomized bench for echo_requester: a responder model answers each say
// and the expected say stream and end-of-run counters come from a run model.
module tb_echo_requester;

    localparam int          TO     = 16;
    localparam logic [31:0] V_STEP = 32'h1;

    logic        clk;
    logic        rst_n;
    logic        start_ena;
    logic [15:0] start_count;
    logic [31:0] start_seed;
    logic        start_rdy;
    logic        say_ena;
    logic [31:0] say_meth;
    logic [31:0] say_v;
    logic        say_rdy;
    logic        heard_ena;
    logic [31:0] heard_meth;
    logic [31:0] heard_v;
    logic        heard_rdy;
    logic        done;
    logic [15:0] pass_count;
    logic [15:0] err_count;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int exp_pass = 0;
    int exp_err  = 0;
    int exp_to   = 0;

    echo_requester #(.TIMEOUT(TO), .V_STEP(V_STEP)) dut (
        .CLK                   (clk),
        .nRST                  (rst_n),
        .start__ENA            (start_ena),
        .start_count           (start_count),
        .start_seed            (start_seed),
        .start__RDY            (start_rdy),
        .request_say__ENA      (say_ena),
        .request_say_meth      (say_meth),
        .request_say_v         (say_v),
        .request_say__RDY      (say_rdy),
        .indication_heard__ENA (heard_ena),
        .indication_heard_meth (heard_meth),
        .indication_heard_v    (heard_v),
        .indication_heard__RDY (heard_rdy),
        .done                  (done),
        .pass_count            (pass_count),
        .err_count             (err_count),
        .timeout               (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start_rdy"}, start_rdy, 1);
        chk({tag, "_say_ena"}, say_ena, 0);
        chk({tag, "_meth"}, say_meth, 0);
        chk({tag, "_v"}, say_v, 0);
        chk({tag, "_heard_rdy"}, heard_rdy, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass_count, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // One programmed run. bad_idx corrupts that reply (v or meth), silent_idx never replies.
    task automatic run(input int count, input logic [31:0] seed, input int bad_idx,
                       input bit bad_meth, input int silent_idx, input int bp_first,
                       input int dly);
        int          waited;
        int          bp;
        int          d;
        logic [31:0] ev;
        @(negedge clk);
        chk("start_rdy", start_rdy, 1);
        start_ena = 1'b1; start_count = 16'(count); start_seed = seed;
        @(posedge clk); #1 start_ena = 1'b0;
        exp_pass = 0; exp_err = 0; exp_to = 0;
        for (int i = 0; i < count; i++) begin
            ev = seed + 32'(i) * V_STEP;
            bp = (i == 0) ? bp_first : int'($urandom_range(0, 2));
            say_rdy = 1'b0;
            for (int c = 0; c < bp; c++) begin
                @(negedge clk); #1;
                chk("bp_ena", say_ena, 0);
                chk("bp_meth", say_meth, 32'(i));
                chk("bp_v", say_v, ev);
            end
            @(negedge clk); say_rdy = 1'b1; #1;
            waited = 0;
            while (!say_ena && waited < 20) begin
                @(negedge clk); #1; waited++;
            end
            chk("say_lat", 32'(waited), 0);
            chk("say_meth", say_meth, 32'(i));
            chk("say_v", say_v, ev);
            @(posedge clk); #1 say_rdy = 1'b0;
            if (i == silent_idx) begin
                waited = 0;
                while (!done && waited < 100) begin
                    @(negedge clk); waited++;
                end
                chk("to_lat", 32'(waited), 32'(TO + 1));
                exp_err++; exp_to = 1;
                break;
            end
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            repeat (d) begin
                @(negedge clk); #1;
                chk("wait_heard_rdy", heard_rdy, 1);
                chk("wait_done", done, 0);
            end
            @(negedge clk);
            heard_ena  = 1'b1;
            heard_meth = 32'(i) ^ ((i == bad_idx && bad_meth) ? 32'h4 : 32'h0);
            heard_v    = ev ^ ((i == bad_idx && !bad_meth) ? 32'h1 : 32'h0);
            if (i == bad_idx) exp_err++; else exp_pass++;
            @(posedge clk); #1 heard_ena = 1'b0;
        end
        @(negedge clk); say_rdy = 1'b1; #1;
        chk("end_done", done, 1);
        chk("end_no_say", say_ena, 0);
        chk("end_pass", pass_count, 32'(exp_pass));
        chk("end_err", err_count, 32'(exp_err));
        chk("end_timeout", timeout, 32'(exp_to));
        say_rdy = 1'b0;
    endtask

    task automatic stray();
        @(negedge clk);
        chk("stray_rdy", heard_rdy, 1);
        heard_ena = 1'b1; heard_meth = $urandom; heard_v = $urandom;
        @(posedge clk); #1 heard_ena = 1'b0;
        exp_err++;
        @(negedge clk); #1;
        chk("stray_err", err_count, 32'(exp_err));
    endtask

    initial begin
        int cnt;
        int bidx;
        rst_n = 1'b0; start_ena = 1'b0; start_count = '0; start_seed = '0;
        say_rdy = 1'b1; heard_ena = 1'b0; heard_meth = '0; heard_v = '0;
        #1;
        check_reset_outputs("rst");
        say_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(4, 32'h100, -1, 1'b0, -1, 0, 2);
        run(4, 32'h100, 2, 1'b0, -1, 0, -1);
        run(4, 32'hFFFF_FFFE, -1, 1'b0, -1, 10, -1);

        run(4, 32'h200, -1, 1'b0, 1, 0, -1);
        stray();

        run(0, 32'h55, -1, 1'b0, -1, 0, -1);
        stray();
        run(3, 32'h300, 0, 1'b1, -1, 1, -1);

        for (int r = 0; r < 8; r++) begin
            cnt  = int'($urandom_range(1, 6));
            bidx = int'($urandom_range(0, 7)) - 1;
            run(cnt, $urandom, bidx, 1'($urandom_range(0, 1)), -1,
                int'($urandom_range(0, 3)), -1);
        end

        @(negedge clk);
        start_ena = 1'b1; start_count = 16'd3; start_seed = 32'hABC;
        @(posedge clk); #1 start_ena = 1'b0;
        @(negedge clk); say_rdy = 1'b1; #1;
        chk("mr_say0", say_ena, 1);
        @(posedge clk); #1 say_rdy = 1'b0;
        @(negedge clk); heard_ena = 1'b1; heard_meth = 32'h0; heard_v = 32'hABC;
        @(posedge clk); #1 heard_ena = 1'b0;
        @(negedge clk); say_rdy = 1'b1;
        @(posedge clk); #1 say_rdy = 1'b0;
        @(negedge clk); #1;
        chk("mr_pass_before", pass_count, 1);
        chk("mr_in_wait", heard_rdy, 1);
        rst_n = 1'b0; say_rdy = 1'b1; #1;
        check_reset_outputs("mr");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("mr_no_say", say_ena, 0);
        end
        say_rdy = 1'b0;
        exp_err = 0;
        stray();
        run(2, 32'h10, -1, 1'b0, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
